// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_STEP = 4;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_RDY  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_wait_cnt.sv
// Loadable down-counter timing the instruction memory read; saturates at zero.
module fetch_wait_cnt #(
    parameter int unsigned RD_WAIT = 2,
    parameter int unsigned W       = $clog2(RD_WAIT + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= W'(RD_WAIT);
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, memory read wait, one-entry {instr, pc} output buffer
// with valid/ready handshake, redirect flush and end-of-program halt.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int unsigned RD_WAIT   = 2,
    parameter int unsigned MEM_LIMIT = 40
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [31:0]        out_pc,
    input  logic               out_ready,
    output logic               halted
);

    localparam int unsigned CNT_W = $clog2(RD_WAIT + 1);
    localparam logic [31:0] LIMIT = 32'(MEM_LIMIT);

    fetch_state_e       state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic               out_valid_q, out_valid_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;
    logic [31:0]        out_pc_q, out_pc_d;
    logic               halted_q, halted_d;

    logic [CNT_W-1:0]   cnt;
    logic               cnt_zero;
    logic               cnt_load;
    logic               capture;
    logic [31:0]        pc_inc;
    logic [31:0]        rd_target;

    fetch_wait_cnt #(
        .RD_WAIT (RD_WAIT),
        .W       (CNT_W)
    ) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cnt_load),
        .value (CNT_W'(RD_WAIT)),
        .count (cnt),
        .zero  (cnt_zero)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;

        rd_target = redirect_pc & ~32'h3;
        pc_inc    = pc_q + 32'(PC_STEP);
        capture   = (state_q == S_RDY) && cnt_zero &&
                    (!out_valid_q || out_ready) && !redirect_valid;
        cnt_load  = redirect_valid || capture;

        // Redirect wins over capture and flushes whatever the buffer holds.
        if (redirect_valid) begin
            pc_d        = rd_target;
            out_valid_d = 1'b0;
            state_d     = (rd_target >= LIMIT) ? S_HALT : S_WAIT;
        end else if (capture) begin
            out_instr_d = imem_instr;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            pc_d        = pc_inc;
            state_d     = (pc_inc >= LIMIT) ? S_HALT : S_WAIT;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            if (state_q == S_WAIT && cnt == CNT_W'(1)) begin
                state_d = S_RDY;
            end
        end

        halted_d = (state_d == S_HALT) && !out_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_WAIT;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            halted_q    <= halted_d;
        end
    end

    assign imem_addr = pc_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with RD_WAIT=2, MEM_LIMIT=20 and a 2-clock memory model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready = 1'b1;
    logic        halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC  (32'd0),
        .RD_WAIT   (2),
        .MEM_LIMIT (20)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .halted         (halted)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    // Memory returns valid data only once the address has been stable for two edges.
    logic [31:0] a1 = '0;
    logic [31:0] a2 = '0;
    always @(posedge clk) begin
        a1 <= imem_addr;
        a2 <= a1;
    end
    assign imem_instr = (a1 == imem_addr && a2 == imem_addr) ? mem_word(imem_addr)
                                                             : 32'hDEAD_BEEF;

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_addr;
        logic        e_halt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rdy, input logic rv, input logic [31:0] rpc,
                       input logic ev, input logic [31:0] epc, input logic [31:0] eaddr,
                       input logic eh);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.e_valid = ev; v.e_pc = epc; v.e_addr = eaddr; v.e_halt = eh;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) begin
            out_ready      = tbl[i].rdy;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            step();
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
            chk($sformatf("v%0d out_pc", i), out_pc, tbl[i].e_pc);
            chk($sformatf("v%0d imem_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("v%0d halted", i), 32'(halted), 32'(tbl[i].e_halt));
            if (tbl[i].e_valid)
                chk($sformatf("v%0d out_instr", i), out_instr, mem_word(tbl[i].e_pc));
        end
        redirect_valid = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " imem_addr"}, imem_addr, 32'd0);
        chk({tag, " halted"}, 32'(halted), 32'd0);
        chk({tag, " out_pc"}, out_pc, 32'd0);
        chk({tag, " out_instr"}, out_instr, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Sequential fetch to halt, then redirect out of halt and into halt space.
        add(1, 0, 0, 0, 32'd0,  32'd0,  0);
        add(1, 0, 0, 0, 32'd0,  32'd0,  0);
        add(1, 0, 0, 1, 32'd0,  32'd4,  0);
        add(1, 0, 0, 0, 32'd0,  32'd4,  0);
        add(1, 0, 0, 0, 32'd0,  32'd4,  0);
        add(1, 0, 0, 1, 32'd4,  32'd8,  0);
        add(1, 0, 0, 0, 32'd4,  32'd8,  0);
        add(1, 0, 0, 0, 32'd4,  32'd8,  0);
        add(1, 0, 0, 1, 32'd8,  32'd12, 0);
        add(1, 0, 0, 0, 32'd8,  32'd12, 0);
        add(1, 0, 0, 0, 32'd8,  32'd12, 0);
        add(1, 0, 0, 1, 32'd12, 32'd16, 0);
        add(1, 0, 0, 0, 32'd12, 32'd16, 0);
        add(1, 0, 0, 0, 32'd12, 32'd16, 0);
        add(1, 0, 0, 1, 32'd16, 32'd20, 0);
        add(1, 0, 0, 0, 32'd16, 32'd20, 1);
        add(1, 0, 0, 0, 32'd16, 32'd20, 1);
        add(1, 1, 32'd4,  0, 32'd16, 32'd4,  0);
        add(1, 0, 0,      0, 32'd16, 32'd4,  0);
        add(1, 0, 0,      0, 32'd16, 32'd4,  0);
        add(1, 0, 0,      1, 32'd4,  32'd8,  0);
        add(1, 1, 32'd24, 0, 32'd4,  32'd24, 1);
        add(1, 0, 0,      0, 32'd4,  32'd24, 1);

        #2;
        chk_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_table();

        // Back-pressure: buffer holds, then pass-through with no valid gap.
        @(negedge clk);
        rst_n = 1'b0;
        out_ready = 1'b0;
        #1;
        chk_reset_state("reset2");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        step();
        chk("bp first valid", 32'(out_valid), 32'd1);
        chk("bp first pc", out_pc, 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("bp hold%0d valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp hold%0d pc", i), out_pc, 32'd0);
            chk($sformatf("bp hold%0d instr", i), out_instr, mem_word(32'd0));
            chk($sformatf("bp hold%0d addr", i), imem_addr, 32'd4);
        end
        out_ready = 1'b1;
        step();
        chk("bp pass valid", 32'(out_valid), 32'd1);
        chk("bp pass pc", out_pc, 32'd4);
        chk("bp pass instr", out_instr, mem_word(32'd4));
        chk("bp pass addr", imem_addr, 32'd8);

        // Redirect to an unaligned target flushes the buffered instruction.
        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_000E;
        step();
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        chk("rd flush valid", 32'(out_valid), 32'd0);
        chk("rd addr", imem_addr, 32'h0C);
        step();
        chk("rd wait1 valid", 32'(out_valid), 32'd0);
        step();
        chk("rd wait2 valid", 32'(out_valid), 32'd0);
        step();
        chk("rd new valid", 32'(out_valid), 32'd1);
        chk("rd new pc", out_pc, 32'h0C);
        chk("rd new instr", out_instr, mem_word(32'h0C));

        // Redirect coinciding with a capture edge suppresses that capture.
        step();
        chk("rc drain valid", 32'(out_valid), 32'd0);
        step();
        chk("rc wait valid", 32'(out_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'd8;
        step();
        redirect_valid = 1'b0;
        chk("rc no capture", 32'(out_valid), 32'd0);
        chk("rc addr", imem_addr, 32'd8);
        step();
        step();
        chk("rc pre valid", 32'(out_valid), 32'd0);
        step();
        chk("rc valid", 32'(out_valid), 32'd1);
        chk("rc pc", out_pc, 32'd8);
        chk("rc instr", out_instr, mem_word(32'd8));

        // Asynchronous reset between edges while counting.
        step();
        chk("ar pre addr", imem_addr, 32'h0C);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_state("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_table();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
